// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit -- sequential signed divider (restoring, one quotient bit/cycle)
//
// Computes LO = A / B (truncated toward zero) and HI = A % B (sign follows
// the dividend) for the HI/LO registers of the multicycle datapath.
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-low reset
//   DivCtrl  in   start request (level); an operation starts on its rising edge
//   A        in   dividend, signed
//   B        in   divisor, signed
//   HI       out  remainder, registered, updated on completion
//   LO       out  quotient, registered, updated on completion
//   DivOut   out  one-cycle done pulse, HI/LO valid while high
//   divZero  out  one-cycle pulse when a started operation had B == 0
//   DivBusy  out  high while a division is in progress
// ---------------------------------------------------------------------------
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             DivOut,
  output logic             divZero,
  output logic             DivBusy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  logic             divctrl_q;
  logic             start;
  logic [WIDTH-1:0] dvd;     // dividend magnitude, shifted out MSB first
  logic [WIDTH-1:0] dsr;     // divisor magnitude
  logic [WIDTH-1:0] rem;     // partial remainder
  logic [WIDTH-1:0] quo;     // quotient magnitude
  logic [CW-1:0]    cnt;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_diff;
  logic             fits;

  // Only the first cycle of a DivCtrl high level starts an operation.
  assign start = DivCtrl & ~divctrl_q;

  // Negating 0x80000000 yields 0x80000000, which read as unsigned is
  // exactly 2^31, so the most negative dividend needs no special case.
  assign abs_a = A[WIDTH-1] ? -A : A;
  assign abs_b = B[WIDTH-1] ? -B : B;

  // The remainder is always below the divisor between iterations, so it fits
  // in WIDTH bits; only the shifted value needs the extra top bit. When the
  // shifted value is >= divisor the true difference is < divisor, so the low
  // WIDTH bits of the subtraction are exact.
  assign rem_shift = {rem, dvd[WIDTH-1]};
  assign fits      = rem_shift >= {1'b0, dsr};
  assign rem_diff  = rem_shift[WIDTH-1:0] - dsr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      divctrl_q <= 1'b0;
      dvd       <= '0;
      dsr       <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      HI        <= '0;
      LO        <= '0;
      DivOut    <= 1'b0;
      divZero   <= 1'b0;
      DivBusy   <= 1'b0;
    end else begin
      divctrl_q <= DivCtrl;
      case (state)
        IDLE: begin
          DivOut  <= 1'b0;
          divZero <= 1'b0;
          if (start) begin
            if (B == '0) begin
              divZero <= 1'b1;
            end else begin
              dvd     <= abs_a;
              dsr     <= abs_b;
              sign_q  <= A[WIDTH-1] ^ B[WIDTH-1];
              sign_r  <= A[WIDTH-1];
              rem     <= '0;
              quo     <= '0;
              cnt     <= '0;
              DivBusy <= 1'b1;
              state   <= RUN;
            end
          end
        end

        RUN: begin
          DivOut  <= 1'b0;
          divZero <= 1'b0;
          dvd     <= {dvd[WIDTH-2:0], 1'b0};
          rem     <= fits ? rem_diff : rem_shift[WIDTH-1:0];
          quo     <= {quo[WIDTH-2:0], fits};
          cnt     <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end

        FIX: begin
          LO      <= sign_q ? -quo : quo;
          HI      <= sign_r ? -rem : rem;
          DivOut  <= 1'b1;
          divZero <= 1'b0;
          DivBusy <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          DivOut  <= 1'b0;
          divZero <= 1'b0;
          DivBusy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit -- directed self-checking bench for div_unit
//
// Expected results are pushed to a scoreboard queue at each start and popped
// by a monitor when DivOut or divZero pulses. Latency, busy time and
// pulse-count checks are done inline in the stimulus sequence.
// ---------------------------------------------------------------------------
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        DivCtrl;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        DivOut;
  logic        divZero;
  logic        DivBusy;

  div_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .DivCtrl (DivCtrl),
    .A       (A),
    .B       (B),
    .HI      (HI),
    .LO      (LO),
    .DivOut  (DivOut),
    .divZero (divZero),
    .DivBusy (DivBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        zero;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        scb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  int          zero_cnt = 0;
  logic [31:0] exp_hi   = '0;
  logic [31:0] exp_lo   = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit signed division avoids the INT_MIN / -1 overflow and
  // truncates toward zero with the remainder taking the dividend's sign.
  task automatic push_model(input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa;
    longint sd;
    longint q;
    longint r;
    if (b == 32'd0) begin
      e.zero = 1'b1;
      e.hi   = exp_hi;
      e.lo   = exp_lo;
    end else begin
      sa     = longint'($signed(a));
      sd     = longint'($signed(b));
      q      = sa / sd;
      r      = sa % sd;
      e.zero = 1'b0;
      e.lo   = q[31:0];
      e.hi   = r[31:0];
      exp_lo = e.lo;
      exp_hi = e.hi;
    end
    scb.push_back(e);
  endtask

  // Monitor: every completion or zero pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (DivOut === 1'b1 || divZero === 1'b1) begin
      exp_t e;
      if (DivOut === 1'b1) done_cnt++;
      if (divZero === 1'b1) zero_cnt++;
      check("pulse_exclusive", {31'd0, DivOut & divZero}, 32'd0);
      if (scb.size() == 0) begin
        check("unexpected_pulse", 32'(scb.size()), 32'd1);
      end else begin
        e = scb.pop_front();
        check("pulse_kind_zero", {31'd0, divZero}, {31'd0, e.zero});
        check("HI", HI, e.hi);
        check("LO", LO, e.lo);
        $display("op done: zero=%0b HI=0x%08h LO=0x%08h", divZero, HI, LO);
      end
    end
  end

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input bit track);
    @(negedge clk);
    A       = a;
    B       = b;
    DivCtrl = 1'b1;
    if (track) push_model(a, b);
  endtask

  // Counts negedges after the start edge until DivOut; scrambles operands and
  // drops DivCtrl right after the start edge.
  task automatic await_done(output int lat, output int busy);
    lat  = 0;
    busy = 0;
    for (int i = 1; i <= 60 && lat == 0; i++) begin
      @(negedge clk);
      if (i == 1) begin
        DivCtrl = 1'b0;
        A       = $urandom;
        B       = $urandom;
      end
      if (DivBusy === 1'b1) busy++;
      if (DivOut === 1'b1) lat = i;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
    int lat;
    int busy;
    launch(a, b, 1'b1);
    await_done(lat, busy);
    check({tag, "_latency"}, 32'(lat), 32'd34);
    check({tag, "_busy_cycles"}, 32'(busy), 32'd33);
    repeat (3) @(negedge clk);
    check({tag, "_HI_hold"}, HI, exp_hi);
    check({tag, "_LO_hold"}, LO, exp_lo);
  endtask

  initial begin
    int snap;
    reset   = 1'b0;
    DivCtrl = 1'b0;
    A       = '0;
    B       = '0;
    repeat (3) @(negedge clk);
    check("rst_HI", HI, 32'd0);
    check("rst_LO", LO, 32'd0);
    check("rst_flags", {29'd0, DivOut, divZero, DivBusy}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Basic sign combinations and the overflow corner.
    run_op(32'd7, 32'd2, "pos_pos");
    run_op(32'hFFFF_FFF9, 32'd2, "neg_pos");
    run_op(32'd7, 32'hFFFF_FFFE, "pos_neg");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, "min_div_m1");
    run_op(32'd7, 32'd2, "preload");

    // Divide by zero: one-cycle flag, no completion, HI/LO unchanged.
    launch(32'd5, 32'd0, 1'b1);
    snap = done_cnt;
    @(negedge clk);
    DivCtrl = 1'b0;
    check("dz_flag_cycle1", {31'd0, divZero}, 32'd1);
    check("dz_busy", {31'd0, DivBusy}, 32'd0);
    @(negedge clk);
    check("dz_flag_cycle2", {31'd0, divZero}, 32'd0);
    repeat (40) @(negedge clk);
    check("dz_no_done", 32'(done_cnt - snap), 32'd0);
    check("dz_HI_kept", HI, 32'd1);
    check("dz_LO_kept", LO, 32'd3);

    // DivCtrl held high for 100 cycles: exactly one operation, A change ignored.
    launch(32'd100, 32'd7, 1'b1);
    snap = done_cnt;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 5) A = 32'd1;
    end
    DivCtrl = 1'b0;
    check("hold_one_done", 32'(done_cnt - snap), 32'd1);
    check("hold_LO", LO, 32'd14);
    check("hold_HI", HI, 32'd2);

    // Reset mid-operation aborts with no completion.
    launch(32'd9, 32'd3, 1'b0);
    snap = done_cnt;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 1) DivCtrl = 1'b0;
    end
    check("abort_busy_before", {31'd0, DivBusy}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_HI", HI, 32'd0);
    check("abort_LO", LO, 32'd0);
    check("abort_flags", {29'd0, DivOut, divZero, DivBusy}, 32'd0);
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - snap), 32'd0);
    check("abort_busy_after", {31'd0, DivBusy}, 32'd0);
    run_op(32'd9, 32'd3, "after_abort");

    // A few random operands against the reference model.
    for (int k = 0; k < 6; k++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = (k % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (rb == 32'd0) rb = 32'd3;
      run_op(ra, rb, "random");
    end

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(scb.size()), 32'd0);
    check("zero_pulse_count", 32'(zero_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
